// File: rtl/tsp_lock_if.sv
// tsp_lock_if
//   Bundles the request/grant/release signals between the TSP swap workers
//   and the central lock arbiter.
//   master modport : worker side (drives en, req, req_v1, req_v2, rel)
//   slave modport  : arbiter side (drives grant, rej, held, lock_map, counters)
//   en        grant enable; releases are honoured regardless
//   req       per-worker level request, held until grant or rej
//   req_v1/2  per-worker window centres, packed at [i*IW +: IW]
//   rel       per-worker release pulse
//   grant/rej one-cycle response pulses
//   held      worker currently owns entries
//   lock_map  bit k set when path entry k is locked
//   grant_cnt, conf_cnt  statistics counters
interface tsp_lock_if #(
  parameter int NWORKERS = 5,
  parameter int NNODES   = 64,
  parameter int IW       = 6
);
  logic                   en;
  logic [NWORKERS-1:0]    req;
  logic [NWORKERS*IW-1:0] req_v1;
  logic [NWORKERS*IW-1:0] req_v2;
  logic [NWORKERS-1:0]    rel;
  logic [NWORKERS-1:0]    grant;
  logic [NWORKERS-1:0]    rej;
  logic [NWORKERS-1:0]    held;
  logic [NNODES-1:0]      lock_map;
  logic [31:0]            grant_cnt;
  logic [31:0]            conf_cnt;

  modport master (
    output en, req, req_v1, req_v2, rel,
    input  grant, rej, held, lock_map, grant_cnt, conf_cnt
  );

  modport slave (
    input  en, req, req_v1, req_v2, rel,
    output grant, rej, held, lock_map, grant_cnt, conf_cnt
  );
endinterface

// File: rtl/tsp_lock_arbiter.sv
// tsp_lock_arbiter
//   Central lock manager for the parallel swap workers of the TSP solver.
//   Each worker asks for exclusive ownership of the two path windows
//   {v1-1,v1,v1+1} and {v2-1,v2,v2+1}. At most one non-conflicting request is
//   granted per cycle, chosen round-robin, and ownership is held until the
//   worker pulses rel.
//   Ports: clk (rising edge), rst_n (async, active low), bus (tsp_lock_if.slave).
//   Optional feature macro TSP_LOCK_STATS_EN: when defined, grant_cnt and
//   conf_cnt are saturating counters; otherwise both are tied to zero.
module tsp_lock_arbiter #(
  parameter int NWORKERS = 5,
  parameter int NNODES   = 64,
  parameter int IW       = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  tsp_lock_if.slave   bus
);

  localparam int WW = (NWORKERS > 1) ? $clog2(NWORKERS) : 1;

  // Mask of the three entries centred on v; out-of-range edges simply drop out.
  function automatic logic [NNODES-1:0] win_mask(input logic [IW-1:0] v);
    logic [NNODES-1:0] m;
    int                vi;
    m  = {NNODES{1'b0}};
    vi = int'(v);
    for (int k = 0; k < NNODES; k++) begin
      if ((k + 1 == vi) || (k == vi) || (k == vi + 1)) begin
        m[k] = 1'b1;
      end else begin
        m[k] = 1'b0;
      end
    end
    return m;
  endfunction

  // Both centres inside [1, NNODES-2] and at least two entries apart.
  function automatic logic is_legal(input logic [IW-1:0] a, input logic [IW-1:0] b);
    int ai;
    int bi;
    int d;
    ai = int'(a);
    bi = int'(b);
    d  = (ai > bi) ? (ai - bi) : (bi - ai);
    return (ai >= 1) && (ai <= NNODES - 2) && (bi >= 1) && (bi <= NNODES - 2) && (d >= 2);
  endfunction

  logic [NNODES-1:0]   lock_map_r;
  logic [WW-1:0]       owner_r [NNODES];
  logic [NWORKERS-1:0] held_r;
  logic [NWORKERS-1:0] grant_r;
  logic [NWORKERS-1:0] rej_r;
  logic [WW-1:0]       rr_ptr_r;

  logic [NNODES-1:0]   need_s [NWORKERS];
  logic [NWORKERS-1:0] legal_s;
  logic [NWORKERS-1:0] free_s;
  logic [NWORKERS-1:0] elig_s;
  logic [NWORKERS-1:0] rej_s;
  logic                found_s;
  logic [WW-1:0]       win_idx_s;
  logic [NWORKERS-1:0] grant_s;

  logic [NNODES-1:0]   lock_nxt_s;
  logic [WW-1:0]       owner_nxt_s [NNODES];
  logic [NWORKERS-1:0] held_nxt_s;
  logic [WW-1:0]       rr_nxt_s;

  // Per-worker legality and conflict evaluation against the registered lock map.
  always_comb begin : req_eval_p
    for (int i = 0; i < NWORKERS; i++) begin
      need_s[i]  = win_mask(bus.req_v1[i*IW +: IW]) | win_mask(bus.req_v2[i*IW +: IW]);
      legal_s[i] = is_legal(bus.req_v1[i*IW +: IW], bus.req_v2[i*IW +: IW]);
      free_s[i]  = ((need_s[i] & lock_map_r) == {NNODES{1'b0}});
    end
    // Requests from a worker that already holds locks are ignored entirely.
    elig_s = bus.req & legal_s & ~held_r & free_s & {NWORKERS{bus.en}};
    rej_s  = bus.req & ~legal_s & ~held_r & {NWORKERS{bus.en}};
  end

  // Round-robin scan starting at rr_ptr; first eligible worker wins.
  always_comb begin : arb_p
    int idx;
    found_s   = 1'b0;
    win_idx_s = {WW{1'b0}};
    for (int k = 0; k < NWORKERS; k++) begin
      idx = (int'(rr_ptr_r) + k) % NWORKERS;
      if (!found_s && elig_s[idx]) begin
        found_s   = 1'b1;
        win_idx_s = WW'(idx);
      end else begin
        found_s   = found_s;
      end
    end
    grant_s = {NWORKERS{1'b0}};
    if (found_s) begin
      grant_s[win_idx_s] = 1'b1;
    end else begin
      grant_s = {NWORKERS{1'b0}};
    end
  end

  // Next lock/owner/held/pointer state: releases first, then the new grant.
  // The grant was qualified on the registered map, so it never touches
  // entries freed in the same cycle.
  always_comb begin : next_state_p
    lock_nxt_s = lock_map_r;
    for (int k = 0; k < NNODES; k++) begin
      owner_nxt_s[k] = owner_r[k];
      for (int i = 0; i < NWORKERS; i++) begin
        if (lock_map_r[k] && (owner_r[k] == WW'(i)) && bus.rel[i]) begin
          lock_nxt_s[k]  = 1'b0;
          owner_nxt_s[k] = {WW{1'b0}};
        end else begin
          lock_nxt_s[k]  = lock_nxt_s[k];
        end
      end
    end
    held_nxt_s = held_r & ~bus.rel;
    rr_nxt_s   = rr_ptr_r;
    if (found_s) begin
      lock_nxt_s = lock_nxt_s | need_s[win_idx_s];
      for (int k = 0; k < NNODES; k++) begin
        if (need_s[win_idx_s][k]) begin
          owner_nxt_s[k] = win_idx_s;
        end else begin
          owner_nxt_s[k] = owner_nxt_s[k];
        end
      end
      held_nxt_s[win_idx_s] = 1'b1;
      if (win_idx_s == WW'(NWORKERS - 1)) begin
        rr_nxt_s = {WW{1'b0}};
      end else begin
        rr_nxt_s = win_idx_s + WW'(1);
      end
    end else begin
      rr_nxt_s = rr_ptr_r;
    end
  end

  // Lock table, ownership, pointer and response pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_map_r <= {NNODES{1'b0}};
      for (int k = 0; k < NNODES; k++) begin
        owner_r[k] <= {WW{1'b0}};
      end
      held_r   <= {NWORKERS{1'b0}};
      grant_r  <= {NWORKERS{1'b0}};
      rej_r    <= {NWORKERS{1'b0}};
      rr_ptr_r <= {WW{1'b0}};
    end else begin
      lock_map_r <= lock_nxt_s;
      for (int k = 0; k < NNODES; k++) begin
        owner_r[k] <= owner_nxt_s[k];
      end
      held_r   <= held_nxt_s;
      grant_r  <= grant_s;
      rej_r    <= rej_s;
      rr_ptr_r <= rr_nxt_s;
    end
  end

  assign bus.grant    = grant_r;
  assign bus.rej      = rej_r;
  assign bus.held     = held_r;
  assign bus.lock_map = lock_map_r;

`ifdef TSP_LOCK_STATS_EN
  logic [31:0] grant_cnt_r;
  logic [31:0] conf_cnt_r;
  logic        blocked_s;

  // A legal, not-held request that overlaps a locked entry counts as blocked.
  always_comb begin : blocked_p
    blocked_s = bus.en && ((bus.req & legal_s & ~held_r & ~free_s) != {NWORKERS{1'b0}});
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_r <= 32'd0;
      conf_cnt_r  <= 32'd0;
    end else begin
      if (found_s && (grant_cnt_r != 32'hFFFF_FFFF)) begin
        grant_cnt_r <= grant_cnt_r + 32'd1;
      end else begin
        grant_cnt_r <= grant_cnt_r;
      end
      if (blocked_s && (conf_cnt_r != 32'hFFFF_FFFF)) begin
        conf_cnt_r <= conf_cnt_r + 32'd1;
      end else begin
        conf_cnt_r <= conf_cnt_r;
      end
    end
  end

  assign bus.grant_cnt = grant_cnt_r;
  assign bus.conf_cnt  = conf_cnt_r;
`else
  assign bus.grant_cnt = 32'd0;
  assign bus.conf_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_tsp_lock_arbiter.sv
// tb_tsp_lock_arbiter
//   Directed scoreboard bench for tsp_lock_arbiter. Stimulus pushes the
//   expected grant/rej response (with lock_map and held after it) into a
//   queue; a negedge monitor pops and compares whenever grant or rej is nonzero.
module tb_tsp_lock_arbiter;
  localparam int NW = 5;
  localparam int NN = 64;
  localparam int IW = 6;
`ifdef TSP_LOCK_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  typedef struct packed {
    logic [NW-1:0] g;
    logic [NW-1:0] r;
    logic [NN-1:0] lm;
    logic [NW-1:0] h;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  tsp_lock_if #(.NWORKERS(NW), .NNODES(NN), .IW(IW)) bus ();

  tsp_lock_arbiter #(.NWORKERS(NW), .NNODES(NN), .IW(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [NN-1:0] win(input int v);
    logic [NN-1:0] three;
    three = 64'd7;
    return three << (v - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    bus.req[i]               = 1'b1;
    bus.req_v1[i*IW +: IW]   = IW'(a);
    bus.req_v2[i*IW +: IW]   = IW'(b);
  endtask

  task automatic push(input logic [NW-1:0] g, input logic [NW-1:0] r,
                      input logic [NN-1:0] lm, input logic [NW-1:0] h);
    exp_t e;
    e.g = g; e.r = r; e.lm = lm; e.h = h;
    q.push_back(e);
  endtask

  // Scoreboard monitor: compares every grant/rej response against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ((bus.grant != '0) || (bus.rej != '0))) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_response grant=%b rej=%b", bus.grant, bus.rej);
      end else begin
        e = q.pop_front();
        chk("mon_grant",    64'(bus.grant),    64'(e.g));
        chk("mon_rej",      64'(bus.rej),      64'(e.r));
        chk("mon_lock_map", bus.lock_map,      e.lm);
        chk("mon_held",     64'(bus.held),     64'(e.h));
      end
    end
  end

  initial begin
    logic [NN-1:0] m;
    rst_n      = 1'b0;
    bus.en     = 1'b1;
    bus.req    = '0;
    bus.req_v1 = '0;
    bus.req_v2 = '0;
    bus.rel    = '0;
    #12;
    chk("rst_grant",    64'(bus.grant),     64'd0);
    chk("rst_rej",      64'(bus.rej),       64'd0);
    chk("rst_held",     64'(bus.held),      64'd0);
    chk("rst_lock_map", bus.lock_map,       64'd0);
    chk("rst_grant_cnt", 64'(bus.grant_cnt), 64'd0);
    chk("rst_conf_cnt", 64'(bus.conf_cnt),  64'd0);
    rst_n = 1'b1;
    tick();

    // Five disjoint requests at once: grants 0..4 on consecutive cycles.
    set_req(0, 2, 10); set_req(1, 14, 22); set_req(2, 26, 34);
    set_req(3, 38, 46); set_req(4, 50, 58);
    m = win(2) | win(10);   push(5'b00001, 5'b0, m, 5'b00001);
    m = m | win(14) | win(22); push(5'b00010, 5'b0, m, 5'b00011);
    m = m | win(26) | win(34); push(5'b00100, 5'b0, m, 5'b00111);
    m = m | win(38) | win(46); push(5'b01000, 5'b0, m, 5'b01111);
    m = m | win(50) | win(58); push(5'b10000, 5'b0, m, 5'b11111);
    for (int i = 0; i < NW; i++) begin
      tick();
      bus.req[i] = 1'b0;
    end
    bus.rel = 5'b11111;
    tick();
    bus.rel = '0;
    chk("relall_lock_map", bus.lock_map, 64'd0);
    chk("relall_held",     64'(bus.held), 64'd0);

    // Pointer wrapped to 0: worker 0 beats worker 4, then worker 4.
    set_req(4, 50, 58); set_req(0, 2, 10);
    push(5'b00001, 5'b0, win(2) | win(10), 5'b00001);
    push(5'b10000, 5'b0, win(2) | win(10) | win(50) | win(58), 5'b10001);
    tick(); bus.req[0] = 1'b0;
    tick(); bus.req[4] = 1'b0;
    bus.rel = 5'b10001;
    tick(); bus.rel = '0;

    // Basic grant of (5,20) to worker 0.
    set_req(0, 5, 20);
    push(5'b00001, 5'b0, win(5) | win(20), 5'b00001);
    tick(); bus.req[0] = 1'b0;
    chk("s1_lock_map", bus.lock_map, 64'h0000_0000_0038_0070);

    // Conflict: worker 1 (6,30) blocked until worker 0 releases.
    set_req(1, 6, 30);
    tick(); tick(); tick();
    bus.rel[0] = 1'b1;
    push(5'b00010, 5'b0, win(6) | win(30), 5'b00010);
    tick(); bus.rel = '0;
    chk("s2_freed_map", bus.lock_map, 64'd0);
    chk("s2_freed_held", 64'(bus.held), 64'd0);
    tick(); bus.req[1] = 1'b0;

    // Illegal requests rejected; held worker's request ignored; stray rel no effect.
    set_req(1, 0, 0);
    set_req(2, 0, 10);
    bus.rel[0] = 1'b1;
    push(5'b0, 5'b00100, win(6) | win(30), 5'b00010);
    tick(); bus.req[2] = 1'b0; bus.rel = '0;
    chk("s4_map_kept",  bus.lock_map, win(6) | win(30));
    chk("s4_held_kept", 64'(bus.held), 64'b00010);
    tick();
    set_req(2, 7, 8);
    push(5'b0, 5'b00100, win(6) | win(30), 5'b00010);
    tick(); bus.req[2] = 1'b0;
    tick(); bus.req[1] = 1'b0;
    bus.rel[1] = 1'b1;
    tick(); bus.rel = '0;
    chk("s4_released", bus.lock_map, 64'd0);

    // en=0: release still processed, pending request waits for en=1.
    set_req(3, 10, 40);
    push(5'b01000, 5'b0, win(10) | win(40), 5'b01000);
    tick(); bus.req[3] = 1'b0;
    bus.en = 1'b0; bus.rel[3] = 1'b1; set_req(4, 14, 50);
    tick(); bus.rel = '0;
    chk("s5_rel_map",  bus.lock_map, 64'd0);
    chk("s5_rel_held", 64'(bus.held), 64'd0);
    tick(); tick();
    bus.en = 1'b1;
    push(5'b10000, 5'b0, win(14) | win(50), 5'b10000);
    tick(); bus.req[4] = 1'b0;
    chk("grant_cnt", 64'(bus.grant_cnt), 64'(STATS * 11));
    chk("conf_cnt",  64'(bus.conf_cnt),  64'(STATS * 4));

    // Three holders, then mid-run reset.
    bus.rel[4] = 1'b1;
    tick(); bus.rel = '0;
    set_req(0, 2, 10); set_req(1, 20, 30); set_req(2, 40, 50);
    push(5'b00001, 5'b0, win(2) | win(10), 5'b00001);
    push(5'b00010, 5'b0, win(2) | win(10) | win(20) | win(30), 5'b00011);
    push(5'b00100, 5'b0, win(2) | win(10) | win(20) | win(30) | win(40) | win(50), 5'b00111);
    tick(); bus.req[0] = 1'b0;
    tick(); bus.req[1] = 1'b0;
    tick(); bus.req[2] = 1'b0;
    tick();
    chk("s6_held_before", 64'(bus.held), 64'b00111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_lock_map", bus.lock_map, 64'd0);
    chk("s6_held",     64'(bus.held), 64'd0);
    chk("s6_grant_cnt", 64'(bus.grant_cnt), 64'd0);
    chk("s6_conf_cnt", 64'(bus.conf_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
